tmcc_frame_sync: RTL and testbench

Frame synchronizer and extractor for the one-seg TMCC channel. Sits directly after the BPSK demapper and consumes its hard-decision bit stream (`valid_raw`/`raw`), one bit per OFDM symbol. It hunts for the alternating 16-bit TMCC sync words, verifies and tracks frame lock, and delivers each locked frame's segment type and 102 TMCC information bits to the downstream carrier-modulation configuration logic.

---
 rtl/tmcc_frame_sync.sv | 132 +++++++++++++
 tb/tb_tmcc_frame_sync.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmcc_frame_sync.sv
// TMCC frame synchronizer for the one-seg channel: hunts for alternating sync
// words, tracks frame lock, and captures segment type and 102 info bits per frame.
module tmcc_frame_sync #(
  parameter logic [15:0] W0       = 16'b0011010111101110,
  parameter int          MISS_MAX = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ce,
  input  logic         valid_raw,
  input  logic         raw,
  output logic         locked,
  output logic         frame_start,
  output logic         sync_pol,
  output logic [2:0]   seg_type,
  output logic         tmcc_valid,
  output logic [101:0] tmcc_info
);

  localparam logic [15:0] W1 = ~W0;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

  state_t         state, state_nxt;
  logic [15:0]    sr;
  logic [15:0]    cand;
  logic [7:0]     idx, idx_nxt;
  logic [2:0]     miss, miss_inc;
  logic           exp_pol;
  logic [2:0]     seg_cap;
  logic [101:0]   info_cap;
  logic           accept, hunt_w0, hunt_w1, exp_match, at_sync, miss_out;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    accept    = ce & valid_raw;
    cand      = {sr[14:0], raw};
    hunt_w0   = (cand == W0);
    hunt_w1   = (cand == W1);
    exp_match = (cand == (exp_pol ? W1 : W0));
    at_sync   = (idx == 8'd16);
    miss_inc  = miss + 3'd1;
    miss_out  = (miss_inc == 3'(MISS_MAX));
    idx_nxt   = (idx == 8'd203) ? 8'd0 : idx + 8'd1;
    state_nxt = state;
    if (accept) begin
      case (state)
        HUNT:    if (hunt_w0 || hunt_w1) state_nxt = VERIFY;
        VERIFY:  if (at_sync) state_nxt = exp_match ? LOCK : HUNT;
        LOCK:    if (at_sync && !exp_match && miss_out) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= HUNT;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr          <= '0;
      idx         <= '0;
      miss        <= '0;
      exp_pol     <= 1'b0;
      seg_cap     <= '0;
      info_cap    <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_pol    <= 1'b0;
      seg_type    <= '0;
      tmcc_valid  <= 1'b0;
      tmcc_info   <= '0;
    end else begin
      frame_start <= 1'b0;
      tmcc_valid  <= 1'b0;
      if (accept) begin
        sr <= cand;
        case (state)
          HUNT: begin
            if (hunt_w0 || hunt_w1) begin
              idx      <= 8'd17;
              exp_pol  <= hunt_w0;
              sync_pol <= hunt_w1;
            end
          end
          VERIFY: begin
            idx <= idx_nxt;
            if (at_sync && exp_match) begin
              exp_pol     <= ~exp_pol;
              sync_pol    <= exp_pol;
              locked      <= 1'b1;
              frame_start <= 1'b1;
            end
          end
          LOCK: begin
            idx <= idx_nxt;
            // Polarity keeps alternating across misses once locked.
            if (at_sync) begin
              exp_pol <= ~exp_pol;
              if (exp_match) begin
                miss        <= '0;
                frame_start <= 1'b1;
                sync_pol    <= exp_pol;
              end else if (miss_out) begin
                miss   <= '0;
                locked <= 1'b0;
              end else begin
                miss <= miss_inc;
              end
            end
            if (idx == 8'd203) begin
              seg_type   <= seg_cap;
              tmcc_info  <= info_cap;
              tmcc_valid <= 1'b1;
            end
          end
          default: ;
        endcase
        if (state != HUNT && idx >= 8'd17 && idx <= 8'd19)
          seg_cap <= {seg_cap[1:0], raw};
        if (state != HUNT && idx >= 8'd20 && idx <= 8'd121)
          info_cap <= {info_cap[100:0], raw};
      end
    end
  end

endmodule

// File: tb/tb_tmcc_frame_sync.sv
// Directed bench for tmcc_frame_sync: acquisition, miss tolerance, wrong
// alternation, stalled input streams and reset during lock.
module tb_tmcc_frame_sync;

  localparam logic [15:0] W0 = 16'b0011010111101110;
  localparam logic [15:0] W1 = ~W0;

  logic         CLK, RST, ce, valid_raw, raw;
  logic         locked, frame_start, sync_pol, tmcc_valid;
  logic [2:0]   seg_type;
  logic [101:0] tmcc_info;

  logic [2:0]   seg_a, seg_b;
  logic [101:0] info_a, info_b;

  int n_tests, n_fail, pw_err, mode;
  int f_fs_cnt, f_fs_idx, f_tv_cnt, f_tv_idx;
  logic f_lock15, f_lock16;
  logic fs_d, tv_d;

  tmcc_frame_sync dut (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_raw(valid_raw), .raw(raw),
    .locked(locked), .frame_start(frame_start), .sync_pol(sync_pol),
    .seg_type(seg_type), .tmcc_valid(tmcc_valid), .tmcc_info(tmcc_info)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Pulses must never be seen high on two consecutive cycles.
  initial begin
    fs_d = 1'b0;
    tv_d = 1'b0;
    pw_err = 0;
  end
  always @(negedge CLK) begin
    if (frame_start === 1'b1 && fs_d) pw_err++;
    if (tmcc_valid === 1'b1 && tv_d) pw_err++;
    fs_d <= (frame_start === 1'b1);
    tv_d <= (tmcc_valid === 1'b1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [15:0] sw, input int i, input bit corrupt,
                                     input logic [2:0] seg, input logic [101:0] info);
    logic [15:0]  t16;
    logic [2:0]   t3;
    logic [101:0] t102;
    if (i >= 1 && i <= 16) begin
      t16 = sw << (i - 1);
      return t16[15] ^ (corrupt && i == 1);
    end
    if (i >= 17 && i <= 19) begin
      t3 = seg << (i - 17);
      return t3[2];
    end
    if (i >= 20 && i <= 121) begin
      t102 = info << (i - 20);
      return t102[101];
    end
    return 1'b0;
  endfunction

  // One accepted bit; outputs are valid #1 after the accepting edge on return.
  task automatic send_bit(input logic b);
    if (mode == 1) begin
      repeat ($urandom_range(1, 5)) begin
        valid_raw = 1'b0;
        raw = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
      end
    end
    valid_raw = 1'b1;
    raw = b;
    if (mode == 2) begin
      ce = ($urandom_range(0, 9) != 0);
      while (!ce) begin
        @(posedge CLK); #1;
        ce = ($urandom_range(0, 9) != 0);
      end
    end
    @(posedge CLK); #1;
    valid_raw = 1'b0;
    ce = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] sw, input int lo, input int hi, input bit corrupt,
                            input logic [2:0] seg, input logic [101:0] info);
    f_fs_cnt = 0; f_fs_idx = -1; f_tv_cnt = 0; f_tv_idx = -1;
    for (int i = lo; i <= hi; i++) begin
      send_bit(frame_bit(sw, i, corrupt, seg, info));
      if (frame_start) begin f_fs_cnt++; f_fs_idx = i; end
      if (tmcc_valid)  begin f_tv_cnt++; f_tv_idx = i; end
      if (i == 15) f_lock15 = locked;
      if (i == 16) f_lock16 = locked;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    valid_raw = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic acquire(input int m);
    mode = m;
    for (int i = 0; i < 37; i++) send_bit(1'(i % 3 == 0));
    send_frame(W0, 0, 203, 0, seg_a, info_a);
    check($sformatf("m%0d f1 locked", m), f_lock16, 0);
    check($sformatf("m%0d f1 fs", m), f_fs_cnt, 0);
    check($sformatf("m%0d f1 tv", m), f_tv_cnt, 0);
    send_frame(W1, 0, 203, 0, seg_a, info_a);
    check($sformatf("m%0d f2 lock pre", m), f_lock15, 0);
    check($sformatf("m%0d f2 lock", m), f_lock16, 1);
    check($sformatf("m%0d f2 fs cnt", m), f_fs_cnt, 1);
    check($sformatf("m%0d f2 fs idx", m), f_fs_idx, 16);
    check($sformatf("m%0d f2 tv cnt", m), f_tv_cnt, 1);
    check($sformatf("m%0d f2 tv idx", m), f_tv_idx, 203);
    check($sformatf("m%0d f2 info", m), tmcc_info, info_a);
    check($sformatf("m%0d f2 seg", m), seg_type, 3'd5);
    check($sformatf("m%0d f2 pol", m), sync_pol, 1);
    send_frame(W0, 0, 203, 0, seg_a, info_a);
    check($sformatf("m%0d f3 fs cnt", m), f_fs_cnt, 1);
    check($sformatf("m%0d f3 tv cnt", m), f_tv_cnt, 1);
    check($sformatf("m%0d f3 info", m), tmcc_info, info_a);
    check($sformatf("m%0d f3 seg", m), seg_type, 3'd5);
    check($sformatf("m%0d f3 pol", m), sync_pol, 0);
    check($sformatf("m%0d f3 locked", m), locked, 1);
    check($sformatf("m%0d pulse width", m), pw_err, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mode = 0;
    f_lock15 = 1'b0; f_lock16 = 1'b0;
    seg_a  = 3'b101;
    info_a = {2'b10, {25{4'hA}}};
    seg_b  = 3'b010;
    info_b = 102'h3_0F1E_2D3C_4B5A_6978_8796_A5B4;
    RST = 1'b1; ce = 1'b1; valid_raw = 1'b0; raw = 1'b0;

    // Reset held with random activity on the inputs.
    for (int c = 0; c < 3; c++) begin
      ce = 1'($urandom_range(0, 1));
      valid_raw = 1'($urandom_range(0, 1));
      raw = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      check($sformatf("reset outs c%0d", c),
            {locked, frame_start, sync_pol, seg_type, tmcc_valid, tmcc_info}, 0);
    end
    RST = 1'b0; ce = 1'b1; valid_raw = 1'b0;
    @(posedge CLK); #1;
    check("locked after reset", locked, 0);

    acquire(0);

    // Single missed sync is tolerated, two in a row drop lock.
    send_frame(W1, 0, 203, 1, seg_a, info_a);
    check("miss1 lock", f_lock16, 1);
    check("miss1 fs", f_fs_cnt, 0);
    check("miss1 tv", f_tv_cnt, 1);
    send_frame(W0, 0, 203, 0, seg_a, info_a);
    check("recover fs", f_fs_cnt, 1);
    send_frame(W1, 0, 203, 1, seg_a, info_a);
    check("miss2a lock", f_lock16, 1);
    check("miss2a tv", f_tv_cnt, 1);
    send_frame(W0, 0, 203, 1, seg_a, info_a);
    check("miss2b lock pre", f_lock15, 1);
    check("miss2b lock", f_lock16, 0);
    check("miss2b tv", f_tv_cnt, 0);

    // Same polarity twice fails verification; W1 then W0 locks.
    send_frame(W0, 0, 203, 0, seg_a, info_a);
    check("alt w0a lock", f_lock16, 0);
    send_frame(W0, 0, 203, 0, seg_a, info_a);
    check("alt w0b lock", f_lock16, 0);
    check("alt w0b fs", f_fs_cnt, 0);
    send_frame(W1, 0, 203, 0, seg_a, info_a);
    check("alt w1 lock", f_lock16, 0);
    send_frame(W0, 0, 203, 0, seg_a, info_a);
    check("alt w0c lock", f_lock16, 1);
    check("alt w0c fs", f_fs_cnt, 1);

    do_reset();
    acquire(1);
    do_reset();
    acquire(2);

    // Reset at B60 of a locked frame; two fresh sync words are needed.
    mode = 0;
    send_frame(W1, 0, 60, 0, seg_a, info_a);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("midlock reset outs",
          {locked, frame_start, sync_pol, seg_type, tmcc_valid, tmcc_info}, 0);
    RST = 1'b0;
    send_frame(W1, 61, 203, 0, seg_a, info_a);
    check("post reset tv", f_tv_cnt, 0);
    send_frame(W0, 0, 203, 0, seg_b, info_b);
    check("relock1 lock", f_lock16, 0);
    check("relock1 fs", f_fs_cnt, 0);
    send_frame(W1, 0, 203, 0, seg_b, info_b);
    check("relock2 lock", f_lock16, 1);
    check("relock2 fs", f_fs_cnt, 1);
    check("relock2 tv", f_tv_cnt, 1);
    check("relock2 info", tmcc_info, info_b);
    check("relock2 seg", seg_type, 3'd2);
    check("relock2 pol", sync_pol, 1);
    check("final pulse width", pw_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
